// File: rtl/counter_seq_ctrl.sv
// Control-word sequencer for the tutorial counter: decodes run/clear/load/
// oneshot/dir from the software register and drives a prescaled up/down counter.
module counter_seq_ctrl #(
    parameter int C_WIDTH          = 32,
    parameter int C_PRESCALE_WIDTH = 16
) (
    input  logic                        user_clk,
    input  logic                        user_rst,
    input  logic [31:0]                 ctrl_word,
    input  logic [C_WIDTH-1:0]          load_value,
    input  logic [C_WIDTH-1:0]          limit,
    input  logic [C_PRESCALE_WIDTH-1:0] prescale,
    output logic [C_WIDTH-1:0]          count,
    output logic                        running,
    output logic                        done,
    output logic                        wrap_pulse,
    output logic [31:0]                 status_word
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_BAD  = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [C_WIDTH-1:0]          count_q, count_d;
    logic [C_PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic                        wrap_pulse_q, wrap_pulse_d;
    logic                        sticky_q, sticky_d;
    logic [15:0]                 wcnt_q, wcnt_d;
    logic                        prev_clr_q, prev_ld_q;

    logic run, oneshot, dir, clear_evt, load_evt, terminal;
    logic unused_ctrl;

    assign run       = ctrl_word[0];
    assign oneshot   = ctrl_word[3];
    assign dir       = ctrl_word[4];
    assign clear_evt = ctrl_word[1] & ~prev_clr_q;
    assign load_evt  = ctrl_word[2] & ~prev_ld_q;
    assign terminal  = dir ? (count_q == '0) : (count_q == limit);
    assign unused_ctrl = ^ctrl_word[31:5];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pre_d        = pre_q;
        wrap_pulse_d = 1'b0;
        sticky_d     = sticky_q;
        wcnt_d       = wcnt_q;
        if (clear_evt) begin
            count_d  = '0;
            pre_d    = '0;
            sticky_d = 1'b0;
            wcnt_d   = '0;
            state_d  = run ? S_RUN : S_IDLE;
        end else if (load_evt) begin
            count_d = load_value;
            pre_d   = '0;
            state_d = run ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_RUN;
                        pre_d   = '0;
                    end
                end
                S_RUN: begin
                    if (!run) begin
                        state_d = S_IDLE;
                        pre_d   = '0;
                    end else if (pre_q != prescale) begin
                        // A shrunk prescale lets pre_cnt run past and wrap around.
                        pre_d = pre_q + 1'b1;
                    end else begin
                        pre_d = '0;
                        if (!terminal) begin
                            count_d = dir ? count_q - 1'b1 : count_q + 1'b1;
                        end else if (oneshot) begin
                            state_d = S_DONE;
                        end else begin
                            count_d      = dir ? limit : '0;
                            wrap_pulse_d = 1'b1;
                            sticky_d     = 1'b1;
                            if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!run) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            pre_q        <= '0;
            wrap_pulse_q <= 1'b0;
            sticky_q     <= 1'b0;
            wcnt_q       <= '0;
            prev_clr_q   <= 1'b0;
            prev_ld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pre_q        <= pre_d;
            wrap_pulse_q <= wrap_pulse_d;
            sticky_q     <= sticky_d;
            wcnt_q       <= wcnt_d;
            prev_clr_q   <= ctrl_word[1];
            prev_ld_q    <= ctrl_word[2];
        end
    end

    assign count      = count_q;
    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign wrap_pulse = wrap_pulse_q;
    // Live oneshot/dir echo is masked so the word reads zero while in reset.
    assign status_word = {wcnt_q, 11'd0,
                          dir & ~user_rst, oneshot & ~user_rst,
                          sticky_q, state_q};

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for the tutorial counter datapath in the user_clk domain. Decodes the 32-bit control word from the ppc2simulink software register into run, clear, load, mode and direction controls, and drives a prescaled up/down counter. Produces a 32-bit status word for a simulink2ppc readback register.

Parameters:
C_WIDTH, 32, counter, load_value and limit width (2..32)
C_PRESCALE_WIDTH, 16, prescale input width

Ports:
user_clk  input  1  user-domain clock; all logic on rising edge
user_rst  input  1  asynchronous, active-high reset
ctrl_word  input  32  software register value, already in user_clk domain; [0] run (level), [1] clear (rising edge), [2] load (rising edge), [3] oneshot, [4] dir (0 up, 1 down), [31:5] ignored
load_value  input  C_WIDTH  value applied on load
limit  input  C_WIDTH  terminal value for up counting; reload value for down counting
prescale  input  C_PRESCALE_WIDTH  counter advances once every prescale+1 cycles
count  output  C_WIDTH  current counter value, registered
running  output  1  high while state is RUN
done  output  1  high while state is DONE
wrap_pulse  output  1  one-cycle pulse on each free-run wrap
status_word  output  32  [1:0] state, [2] wrap sticky, [3] oneshot, [4] dir, [15:5] zero, [31:16] wrap_count (saturating)

Behaviour:
- Reset (async): state IDLE, count 0, pre_cnt 0, wrap_pulse 0, wrap sticky 0, wrap_count 0, clear/load edge registers 0. Outputs: running 0, done 0, status_word 0.
- Edge detection: clear_evt = ctrl_word[1] & ~prev[1]; load_evt likewise for bit 2. The prev registers reset to 0, so a bit already high at reset release gives exactly one event on the first edge.
- State encoding: IDLE=0, RUN=1, DONE=2. Code 3 is unreachable and recovers to IDLE.
- Priority per edge, highest first: clear_evt, then load_evt, then normal sequencing.
- clear_evt:
  - count <= 0, pre_cnt <= 0.
  - wrap sticky <= 0, wrap_count <= 0.
  - state <= RUN if run=1, else IDLE.
- load_evt:
  - count <= load_value, pre_cnt <= 0.
  - state <= RUN if run=1, else IDLE.
  - wrap statistics are kept.
- IDLE:
  - Count and pre_cnt are held.
  - run=1: state <= RUN, pre_cnt <= 0.
- RUN:
  - run=0: state <= IDLE, pre_cnt <= 0, count held (pause).
  - Otherwise pre_cnt counts up each edge. tick = (pre_cnt == prescale); on tick, pre_cnt <= 0.
- Tick, up (dir=0):
  - count != limit: count <= count+1.
  - count == limit and oneshot=1: state <= DONE, count held.
  - count == limit and oneshot=0: count <= 0, wrap event.
- Tick, down (dir=1):
  - count != 0: count <= count-1.
  - count == 0 and oneshot=1: state <= DONE, count held.
  - count == 0 and oneshot=0: count <= limit, wrap event.
- Up counting with count > limit (after a load) increments modulo 2^C_WIDTH until it equals limit. No early terminal.
- Wrap event, registered same edge: wrap_pulse=1 for one cycle, wrap sticky <= 1, wrap_count <= wrap_count+1, saturating at 0xFFFF.
- DONE: count frozen. run=0 gives state <= IDLE. A clear or load event exits DONE per the priority rules.
- dir and oneshot are sampled live each tick. Changing them mid-run takes effect on the next tick.
- Timing:
  - With prescale=0, count first changes one edge after the edge that entered RUN.
  - With prescale=P, the first change is P+1 edges after entry.
  - prescale changed mid-run: the compare uses the new value immediately. If pre_cnt > prescale, it runs past and wraps modulo 2^C_PRESCALE_WIDTH.
- Reset asserted mid-operation aborts immediately to the reset values above.

Test Plan:
- Reset, then ctrl_word=0x1, prescale=0, limit=5, up, free-run -> count 1,2,3,4,5,0,... on successive edges; wrap_pulse high one cycle as count goes 5->0; status_word[31:16]=1 after first wrap.
- ctrl_word=0x9 (run+oneshot), limit=3 -> count reaches 3, then done=1, running=0, status_word[1:0]=2. Then ctrl_word=0x8 -> IDLE, done=0, count stays 3.
- Down mode, ctrl_word=0x11, limit=2, load_value=1, load edge (ctrl_word=0x15) -> count 1,0,2,1,0,2; wrap_pulse at each 0->2.
- prescale=3, run -> count advances every 4 cycles; run dropped mid-interval -> count held; re-raise run -> next advance after 4 cycles.
- Clear and load bits rise on the same edge -> count=0, not load_value; wrap stats zeroed; state follows run. Holding the bits high gives no repeat event.
- Reset released with ctrl_word=0x6 -> exactly one clear event; count=0; no load applied. Reset pulsed mid-count -> all outputs 0 asynchronously.
